// File: rtl/cofre_pkg.sv
// Shared types and constants for the safe controller.
package cofre_pkg;
   localparam int SENHA_W   = 4;
   localparam int PERTO_MAX = 3;

   typedef enum logic [1:0] {
      FECHADO,
      AVALIA,
      ABERTO,
      BLOQUEADO
   } estado_t;
endpackage

// File: rtl/cofre_avaliador.sv
// Combinational attempt classifier: unsigned distance without wrap, exact match and near flags.
module cofre_avaliador
   import cofre_pkg::*;
(
   input  logic [SENHA_W-1:0] senha,
   input  logic [SENHA_W-1:0] tentativa,
   output logic [SENHA_W-1:0] diff,
   output logic               igual,
   output logic               perto
);

   always_comb begin
      if (senha >= tentativa) diff = senha - tentativa;
      else                    diff = tentativa - senha;
      igual = (diff == '0);
      perto = !igual && (diff <= SENHA_W'(PERTO_MAX));
   end

endmodule

// File: rtl/cofre_controle.sv
// Safe controller: password/attempt registers, failure counter and timed lockout.
//   state     | meaning
//   FECHADO   | closed, waiting for an attempt
//   AVALIA    | one-cycle evaluation of the captured attempt
//   ABERTO    | open, password may be reprogrammed
//   BLOQUEADO | lockout, counting down before accepting attempts again
module cofre_controle
   import cofre_pkg::*;
#(
   parameter int                 MAX_FALHAS    = 3,
   parameter int                 BLOQ_CICLOS   = 16,
   parameter logic [SENHA_W-1:0] SENHA_INICIAL = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [SENHA_W-1:0]                tentativa,
   input  logic                              confirmar,
   input  logic [SENHA_W-1:0]                nova_senha,
   input  logic                              programar,
   input  logic                              fechar,
   output logic                              led0,
   output logic                              led1,
   output logic                              led2,
   output logic [SENHA_W-1:0]                diferenca,
   output logic                              bloqueado,
   output logic [$clog2(MAX_FALHAS+1)-1:0]   falhas
);

   localparam int FALHAS_W = $clog2(MAX_FALHAS + 1);
   localparam int CNT_W    = (BLOQ_CICLOS > 1) ? $clog2(BLOQ_CICLOS) : 1;

   estado_t             estado, estado_n;
   logic [SENHA_W-1:0]  senha, senha_n;
   logic [SENHA_W-1:0]  tent_q, tent_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic                led1_n, led2_n;
   logic [SENHA_W-1:0]  dif_n;
   logic [FALHAS_W-1:0] falhas_n, falhas_inc;
   logic [SENHA_W-1:0]  diff;
   logic                igual, perto;

   cofre_avaliador u_avaliador (
      .senha     (senha),
      .tentativa (tent_q),
      .diff      (diff),
      .igual     (igual),
      .perto     (perto)
   );

   // led0 and bloqueado come straight from the state register, so they stay registered.
   assign led0      = (estado == ABERTO);
   assign bloqueado = (estado == BLOQUEADO);

   always_comb begin
      estado_n   = estado;
      senha_n    = senha;
      tent_n     = tent_q;
      cnt_n      = cnt;
      led1_n     = led1;
      led2_n     = led2;
      dif_n      = diferenca;
      falhas_n   = falhas;
      falhas_inc = (falhas == FALHAS_W'(MAX_FALHAS)) ? falhas : falhas + FALHAS_W'(1);
      case (estado)
         FECHADO: begin
            if (confirmar) begin
               tent_n   = tentativa;
               led1_n   = 1'b0;
               led2_n   = 1'b0;
               estado_n = AVALIA;
            end
         end
         AVALIA: begin
            dif_n = diff;
            if (igual) begin
               estado_n = ABERTO;
               falhas_n = '0;
               led1_n   = 1'b0;
               led2_n   = 1'b0;
            end else begin
               led1_n   = perto;
               led2_n   = !perto;
               falhas_n = falhas_inc;
               if (falhas_inc == FALHAS_W'(MAX_FALHAS)) begin
                  estado_n = BLOQUEADO;
                  cnt_n    = CNT_W'(BLOQ_CICLOS - 1);
               end else begin
                  estado_n = FECHADO;
               end
            end
         end
         ABERTO: begin
            if (programar) senha_n  = nova_senha;
            if (fechar)    estado_n = FECHADO;
         end
         BLOQUEADO: begin
            // led1 is deliberately left alone so the last near-miss stays visible.
            if (cnt == '0) begin
               estado_n = FECHADO;
               falhas_n = '0;
               led2_n   = 1'b0;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: estado_n = FECHADO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado    <= FECHADO;
         senha     <= SENHA_INICIAL;
         tent_q    <= '0;
         cnt       <= '0;
         led1      <= 1'b0;
         led2      <= 1'b0;
         diferenca <= '0;
         falhas    <= '0;
      end else begin
         estado    <= estado_n;
         senha     <= senha_n;
         tent_q    <= tent_n;
         cnt       <= cnt_n;
         led1      <= led1_n;
         led2      <= led2_n;
         diferenca <= dif_n;
         falhas    <= falhas_n;
      end
   end

endmodule

// File: doc/cofre_controle.md
# cofre_controle

Sequential controller for the 4-bit safe (cofre). It holds the stored password and registers each user attempt, then classifies it as open, near (within 3 units) or wrong. It counts consecutive failed attempts and enforces a timed lockout after too many failures. It also allows the password to be reprogrammed only while the safe is open, and it drives the safe's LED outputs from registered state.

## Interface
- `MAX_FALHAS`, default 3: consecutive failed attempts that trigger lockout (≥1).
- `BLOQ_CICLOS`, default 16: clock cycles spent in lockout (≥1).
- `SENHA_INICIAL`, default 4'd0: password loaded on reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tentativa`  in  4  user attempt; sampled only on the edge where `confirmar` is accepted.
- `confirmar`  in  1  submit-attempt strobe.
- `nova_senha`  in  4  replacement password; sampled when `programar` is accepted.
- `programar`  in  1  load-password strobe; honoured only in ABERTO.
- `fechar`  in  1  close-safe strobe; honoured only in ABERTO.
- `led0`  out  1  safe open (state ABERTO).
- `led1`  out  1  last attempt failed with |diff| in 1..3.
- `led2`  out  1  last attempt failed with |diff| ≥ 4.
- `diferenca`  out  4  |senha − tentativa| of the last evaluated attempt.
- `bloqueado`  out  1  lockout active.
- `falhas`  out  $clog2(MAX_FALHAS+1)  consecutive failed-attempt count.

## Operation
- States: FECHADO, AVALIA, ABERTO, BLOQUEADO.
- Reset: state FECHADO, senha = SENHA_INICIAL, falhas = 0, lockout counter = 0, every output 0.
- FECHADO:
  - `confirmar` = 1 → capture `tentativa` into the attempt register.
  - Clear `led1` and `led2`, then go to AVALIA.
  - `programar` and `fechar` are ignored.
- AVALIA takes one cycle. It computes diff = |senha − captured| as a 4-bit unsigned value (no wrap: the larger minus the smaller) and registers it into `diferenca`.
  - diff = 0 → ABERTO; falhas ← 0; led1 = led2 = 0.
  - diff 1..3 → led1 ← 1; falhas ← falhas+1.
  - diff ≥ 4 → led2 ← 1; falhas ← falhas+1.
  - On a failure, if the new falhas = MAX_FALHAS, go to BLOQUEADO and load the lockout counter with BLOQ_CICLOS−1. Otherwise go to FECHADO.
- ABERTO: `led0` = 1.
  - `programar` → senha ← `nova_senha`.
  - `fechar` → FECHADO, led0 ← 0.
  - Both strobes on the same edge: the new password is stored and the safe closes.
- BLOQUEADO: `bloqueado` = 1, and the counter decrements every cycle.
  - The edge at which the counter reads 0 → FECHADO; falhas ← 0; bloqueado ← 0; led2 ← 0. `led1` keeps the value set by the final failed attempt, cleared on the next accepted `confirmar`.
- `confirmar` outside FECHADO is ignored and not queued.
- `falhas` saturates at MAX_FALHAS and never wraps.
- `rst` asserted in any state, including mid-lockout or in AVALIA, returns to the reset values on that edge. A reprogrammed password is lost on reset.

## Timing
- Latency: `confirmar` accepted at edge k → AVALIA after edge k → result on led0/led1/led2/diferenca/falhas/bloqueado after edge k+1 (2 cycles).
- `led1` and `led2` read 0 from edge k until the result appears.
- Next attempt: `confirmar` is accepted at the earliest at edge k+2, in FECHADO.
- Lockout: `bloqueado` is high for exactly BLOQ_CICLOS cycles. `confirmar` can be accepted on the first FECHADO edge afterwards.
- Strobes are level-sampled per edge. A strobe held high repeats its action on every edge where it is legal, for example one attempt every 2 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package `cofre_pkg`: state enum (FECHADO, AVALIA, ABERTO, BLOQUEADO), `SENHA_W` = 4, and `PERTO_MAX` = 3 (the near threshold).
- Sub-module `cofre_avaliador`: combinational. Inputs are senha and attempt; outputs are `diff[3:0]`, `igual` and `perto` (1 ≤ diff ≤ PERTO_MAX). Instantiated once in the controller.
- Controller holds the FSM, password register, attempt register, falhas counter and lockout counter.

## Test plan
- Reset, then `tentativa` = 0, `confirmar` → 2 cycles later led0 = 1, diferenca = 0, falhas = 0.
- In ABERTO, `programar` with `nova_senha` = 9 and `fechar` on the same edge. Then attempt 7 → led1 = 1, diferenca = 2, falhas = 1. Then attempt 9 → led0 = 1, falhas = 0.
- senha = 9, attempt 2 → led2 = 1, diferenca = 7. Attempt 15 → led2 = 1, diferenca = 6, no wrap.
- Three failures (4, 12, 1 against senha 0) → bloqueado = 1 for exactly 16 cycles. `confirmar` with the correct password during lockout is ignored. After lockout, falhas = 0 and the correct attempt opens the safe.
- `confirmar` held high during FECHADO/AVALIA → one evaluation every 2 cycles. `confirmar` pulsed in ABERTO → no effect.
- `rst` asserted mid-lockout and in AVALIA → next cycle all outputs are 0, senha = SENHA_INICIAL, and a subsequent attempt of 0 opens the safe.
